// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width, FSM state encodings and error bit indices for the FIFO read side
package fifo_pkg;
   localparam int WIDTH = 16;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
   localparam int ERR_UNDER = 0;
   localparam int ERR_OVER = 1;
endpackage

// File: rtl/drain_buf.sv
// drain_buf: circular output buffer with push/pop and occupancy; head reads as zero when empty
module drain_buf #(
   parameter int W = 16,
   parameter int DEPTH = 2,
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [OW-1:0] occ
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   assign dout = occ == '0 ? '0 : mem[rp];
   // storage write at the tail
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   // pointers wrap at DEPTH; push and pop together leave occupancy unchanged
   always_ff @(posedge clk)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         occ <= '0;
      end else begin
         if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
         if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
         occ <= occ + OW'(push) - OW'(pop);
      end
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: credit-based FIFO read master feeding a valid/ready stream; optional burst mode via DRAIN_BURST_EN
module fifo_drain
   import fifo_pkg::*;
#(
   parameter int WIDTH = fifo_pkg::WIDTH,
   parameter int RD_LAT = 1,
   parameter int BUF_DEPTH = 2,
   parameter int CNT_W = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             fifo_rd,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_valid,
   input  logic             fifo_empty,
   input  logic             fifo_almostfull,
   input  logic             fifo_under,
   input  logic             fifo_over,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt,
   output logic [1:0]       err
);
   localparam int OW = $clog2(BUF_DEPTH + 1);
   state_t state, nxt;
   logic [RD_LAT-1:0] sr;
   logic [OW-1:0] occ;
   logic pop, push, allow, credit;
   assign m_valid = occ != '0;
   assign pop = m_valid && m_ready;
   assign push = fifo_valid && sr[RD_LAT-1];
   assign credit = int'(occ) - int'(pop) + $countones(sr) + 1 <= BUF_DEPTH;
   assign fifo_rd = state == RUN && !fifo_empty && allow && credit;
   assign busy = state != IDLE;
`ifdef DRAIN_BURST_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic burst;
   logic [TW-1:0] tmr;
   assign allow = burst || fifo_almostfull || tmr == TW'(TIMEOUT - 1);
   // WAIT sub-state timer: burst starts on almostfull or timeout, ends when the FIFO empties
   always_ff @(posedge clk)
      if (rst || state != RUN) begin
         burst <= 1'b0;
         tmr <= '0;
      end else if (burst && fifo_empty) begin
         burst <= 1'b0;
         tmr <= '0;
      end else if (!burst && !fifo_empty) begin
         if (allow) burst <= 1'b1;
         else tmr <= tmr + 1'b1;
      end
`else
   logic unused_af;
   localparam int unused_timeout = TIMEOUT;
   assign unused_af = fifo_almostfull;
   assign allow = 1'b1;
`endif
   drain_buf #(.W(WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
      .clk(clk), .rst(rst), .push(push), .din(fifo_dout), .pop(pop), .dout(m_data), .occ(occ)
   );
   // next state: DRAIN waits for in-flight reads and buffered words before idling
   always_comb begin
      nxt = state;
      nxt = state == IDLE ? (enable ? RUN : IDLE)
          : state == RUN  ? (enable ? RUN : DRAIN)
          : enable ? RUN : (sr == '0 && occ == '0 ? IDLE : DRAIN);
   end
   // state, in-flight read pipeline, transfer count and sticky errors
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         sr <= '0;
         word_cnt <= '0;
         err <= '0;
      end else begin
         state <= nxt;
         sr[0] <= fifo_rd;
         for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
         word_cnt <= word_cnt + CNT_W'(pop);
         if (fifo_under) err[ERR_UNDER] <= 1'b1;
         if (fifo_over) err[ERR_OVER] <= 1'b1;
      end
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed and randomized checks of fifo_drain against a queue-based FIFO and stream model
module tb_fifo_drain;
   logic clk = 1'b0;
   logic rst, enable, fifo_rd, fifo_valid, fifo_empty, fifo_almostfull, fifo_under, fifo_over;
   logic m_valid, m_ready, busy;
   logic [15:0] fifo_dout, m_data, word_cnt;
   logic [1:0] err;
   int checks = 0, failures = 0;
   logic [15:0] q[$], expq[$], cnt_model;
   logic pend_v, prev_stall, rd, acc;
   logic [15:0] pend_d, prev_data;
   int cyc_no, first_acc, last_acc, nacc, nreads, base;

   fifo_drain dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
      .fifo_valid(fifo_valid), .fifo_empty(fifo_empty), .fifo_almostfull(fifo_almostfull),
      .fifo_under(fifo_under), .fifo_over(fifo_over), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .busy(busy), .word_cnt(word_cnt), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: present FIFO model outputs, check the stream, then advance the FIFO model
   task automatic tick();
      fifo_empty = q.size() == 0;
      fifo_valid = pend_v;
      fifo_dout = pend_v ? pend_d : 16'hdead;
      #1;
      chk("rd_while_empty", fifo_rd && fifo_empty, 0);
      if (prev_stall) chk("stall_hold", m_data, prev_data);
      acc = m_valid && m_ready && !rst;
      if (acc) begin
         if (expq.size() == 0) chk("extra_word", 1, 0);
         else chk("stream_data", m_data, expq.pop_front());
         cnt_model++;
         nacc++;
         if (first_acc < 0) first_acc = cyc_no;
         last_acc = cyc_no;
      end
      prev_stall = m_valid && !m_ready && !rst;
      prev_data = m_data;
      rd = fifo_rd && !rst;
      @(posedge clk);
      #1;
      cyc_no++;
      if (rd) begin
         pend_d = q.pop_front();
         pend_v = 1'b1;
         expq.push_back(pend_d);
         nreads++;
      end else pend_v = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_almostfull = 1'b0;
      fifo_under = 1'b0; fifo_over = 1'b0; pend_v = 1'b0; pend_d = '0;
      prev_stall = 1'b0; prev_data = '0; cnt_model = '0;
      cyc_no = 0; nacc = 0; nreads = 0; first_acc = -1; last_acc = -1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_err", err, 0);

      for (int i = 1; i <= 9; i++) q.push_back(16'(i));
      enable = 1'b1; m_ready = 1'b1; nacc = 0; first_acc = -1;
      for (int i = 0; i < 40 && nacc < 9; i++) tick();
      chk("burst9_count", nacc, 9);
      chk("burst9_rate", last_acc - first_acc, 8);
      tick();
      chk("burst9_word_cnt", word_cnt, 9);
      chk("burst9_err", err, 0);
      enable = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();
      chk("burst9_idle", busy, 0);

      for (int i = 1; i <= 4; i++) q.push_back(16'(i));
      enable = 1'b1; nacc = 0;
      for (int i = 0; i < 60 && nacc < 4; i++) begin
         m_ready = i % 3 == 0;
         tick();
      end
      chk("stall_count", nacc, 4);
      chk("stall_left", expq.size(), 0);
      m_ready = 1'b1; enable = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();

      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(3, 12);
         for (int i = 0; i < n; i++) q.push_back(16'($urandom));
         enable = 1'b1; nacc = 0;
         for (int i = 0; i < 300 && nacc < n; i++) begin
            m_ready = $urandom_range(0, 9) < 6;
            tick();
         end
         chk("rand_count", nacc, n);
         m_ready = 1'b1; tick();
         chk("rand_word_cnt", word_cnt, cnt_model);
      end
      enable = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();

      for (int i = 1; i <= 6; i++) q.push_back(16'(16'h100 + i));
      enable = 1'b1; m_ready = 1'b1; nacc = 0; base = nreads;
      for (int i = 0; i < 20 && nreads - base < 2; i++) tick();
      enable = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();
      chk("drop_busy", busy, 0);
      chk("drop_all_delivered", nacc, nreads - base);
      chk("drop_left", expq.size(), 0);
      tick();
      chk("drop_no_rd", fifo_rd, 0);
      q.delete();

      for (int i = 0; i < 4; i++) q.push_back(16'(16'h200 + i));
      enable = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 20 && !m_valid; i++) tick();
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; enable = 1'b0;
      q.delete(); expq.delete(); cnt_model = '0;
      pend_v = 1'b1; pend_d = 16'hbeef;
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_word_cnt", word_cnt, 0);
      chk("mid_rst_busy", busy, 0);
      m_ready = 1'b1;
      tick(); tick();
      chk("late_valid_ignored", m_valid, 0);
      chk("late_valid_cnt", word_cnt, 0);

      fifo_over = 1'b1; tick(); fifo_over = 1'b0;
      chk("err_over", err, 2'b10);
      fifo_under = 1'b1; tick(); fifo_under = 1'b0;
      chk("err_both", err, 2'b11);
      tick(); tick(); tick();
      chk("err_sticky", err, 2'b11);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("err_cleared", err, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
